mem_arbiter: RTL

- Parametrised N-channel memory-bus arbiter; successor to the ad-hoc fetch/exec request mux in the 8-bit core top.
- Arbitrates single-transaction memory requests from any number of pipeline stages and DMA-style requesters onto one mem_req/mem_ready bus.
- Adds selectable fixed-priority or round-robin policy, registered grant, latched bus signals and a per-channel lock for multi-byte bursts (e.g. 16-bit instruction fetch).
- Sits between the stage units and the core's external memory port; the core top keeps the tristate data pad.

---
 rtl/bus_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus arbiter and related bus logic.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Low bit of channel i's field inside a packed per-channel vector.
    function automatic int slice_lsb(input int ch, input int field_w);
        return ch * field_w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, grouped as one bus.
interface mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_lock;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_ready;
    logic [DATA_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        grant;
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_ready;
    logic [DATA_W-1:0]        mem_rdata;

    // The arbiter masters the memory bus and answers the requesters.
    modport master (
        input  ch_req, ch_lock, ch_we, ch_addr, ch_wdata, mem_ready, mem_rdata,
        output ch_ready, ch_rdata, grant, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory: everything the arbiter does not drive.
    modport slave (
        output ch_req, ch_lock, ch_we, ch_addr, ch_wdata, mem_ready, mem_rdata,
        input  ch_ready, ch_rdata, grant, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_pick.sv
// Rotate-then-priority-encode picker: first asserted request at or after
// the start index (wrapping), or lowest index in fixed mode.
module arb_pick
    import bus_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start,
    input  logic              mode,
    output logic [NUM_CH-1:0] onehot,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Walk the channels from the rotated base and keep the first requester.
    always_comb begin
        int base;
        int cand;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        base   = (mode == ARB_FIXED) ? 0 : int'(start);
        for (int k = 0; k < NUM_CH; k++) begin
            cand = base + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = IDX_W'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory-bus arbiter with registered grant and bus signals,
// fixed or round-robin policy and per-channel lock for bursts.
module mem_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
    localparam logic PICK_MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

    arb_state_e        state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]  pick_start;
    logic [NUM_CH-1:0] pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [IDX_W-1:0]  sel_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    // Round-robin search begins one past the last IDLE winner.
    assign pick_start = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + 1'b1;

    arb_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (bus.ch_req),
        .start  (pick_start),
        .mode   (PICK_MODE),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // New winner in IDLE, current owner when re-issuing from HOLD.
    assign sel_idx   = (state_q == ST_IDLE) ? pick_idx : owner_q;
    assign sel_addr  = bus.ch_addr[slice_lsb(int'(sel_idx), ADDR_W) +: ADDR_W];
    assign sel_wdata = bus.ch_wdata[slice_lsb(int'(sel_idx), DATA_W) +: DATA_W];
    assign sel_we    = bus.ch_we[sel_idx];

    assign bus.grant     = grant_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ch_ready  = {NUM_CH{bus.mem_ready & mem_req_q}} & grant_q;
    assign bus.ch_rdata  = bus.mem_rdata;

    // Next-state and next-bus-value logic for the IDLE/BUSY/HOLD sequencer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_onehot;
                    owner_d     = pick_idx;
                    rr_ptr_d    = pick_idx;
                    mem_req_d   = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (bus.ch_lock[owner_q]) begin
                        state_d = ST_HOLD;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (!bus.ch_req[owner_q]) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    grant_d   = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.ch_req[owner_q]) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = ST_BUSY;
                end else if (!bus.ch_lock[owner_q]) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d   = '0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and bus registers; reset parks the pointer so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= LAST_CH;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
